// File: rtl/counter_193_driver.sv
// Control-side sequencer for cascaded 74x193 counters: CPU/CPD count pulses, /PL and CLR strobes,
// shadow count with carry/borrow capture. Optional q readback check: COUNTER_193_DRIVER_CHECK_EN.
module counter_193_driver #(
    parameter int WIDTH    = 4,
    parameter int PULSE_LO = 2,
    parameter int PULSE_HI = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_arg,
    output logic             o_done,
    output logic             o_carry,
    output logic             o_borrow,
    output logic [WIDTH-1:0] o_shadow,
    output logic             o_clr,
    output logic             o_npl,
    output logic [WIDTH-1:0] o_p,
    output logic             o_cpu,
    output logic             o_cpd,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_ntcu,
    input  logic             i_ntcd,
    output logic             o_err
);
    localparam int PMAX = (PULSE_LO > PULSE_HI) ? PULSE_LO : PULSE_HI;
    localparam int CW   = $clog2(PMAX) + 1;
    localparam logic [CW-1:0] LO_LAST = CW'(PULSE_LO - 1);
    localparam logic [CW-1:0] HI_LAST = CW'(PULSE_HI - 1);

    localparam logic [1:0] OP_UP = 2'b00;
    localparam logic [1:0] OP_DN = 2'b01;
    localparam logic [1:0] OP_LD = 2'b10;
    localparam logic [1:0] OP_CL = 2'b11;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_LOW, S_HIGH, S_LOAD, S_DONE
`ifdef COUNTER_193_DRIVER_CHECK_EN
        , S_CHECK
`endif
    } state_t;

`ifdef COUNTER_193_DRIVER_CHECK_EN
    localparam state_t S_FIN = S_CHECK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] rem;
    } cmd_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_rst_q;
    cmd_t             r_cmd;
    logic [CW-1:0]    r_tmr;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_p;
    logic             r_carry;
    logic             r_borrow;
    logic             r_clr;
    logic             r_npl;
    logic             r_cpu;
    logic             r_cpd;
    logic             w_accept;
    logic             w_lo_last;
    logic             w_hi_last;
    logic [1:0]       w_op_nxt;
    logic             w_clr_n;
    logic             w_npl_n;
    logic             w_cpu_n;
    logic             w_cpd_n;

    assign w_accept  = (r_state == S_IDLE) && i_cmd_valid;
    assign w_lo_last = (r_tmr == LO_LAST);
    assign w_hi_last = (r_tmr == HI_LAST);
    assign w_op_nxt  = w_accept ? i_cmd_op : r_cmd.op;

    // r_rst_q holds CLEAR for one full clock after reset is released
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_CLEAR;
            r_rst_q <= 1'b1;
        end else begin
            r_state <= w_next;
            r_rst_q <= 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: w_next = r_rst_q ? S_CLEAR : S_IDLE;
            S_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_op[1])
                        w_next = S_LOAD;
                    else if (i_cmd_arg == '0)
                        w_next = S_FIN;
                    else
                        w_next = S_LOW;
                end
            end
            S_LOW:   if (w_lo_last) w_next = S_HIGH;
            S_HIGH:  if (w_hi_last) w_next = (r_cmd.rem == WIDTH'(1)) ? S_FIN : S_LOW;
            S_LOAD:  if (w_lo_last) w_next = S_FIN;
`ifdef COUNTER_193_DRIVER_CHECK_EN
            S_CHECK: w_next = S_DONE;
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_CLEAR;
        endcase
    end

    // Strobes are decoded from the next state and registered, so the 193 clock
    // inputs never see decode glitches yet still track the state cycle-for-cycle.
    always_comb begin
        w_clr_n = 1'b0;
        w_npl_n = 1'b1;
        w_cpu_n = 1'b1;
        w_cpd_n = 1'b1;
        case (w_next)
            S_CLEAR: w_clr_n = 1'b1;
            S_LOW: begin
                w_cpu_n = (w_op_nxt != OP_UP);
                w_cpd_n = (w_op_nxt != OP_DN);
            end
            S_LOAD: begin
                w_npl_n = (w_op_nxt != OP_LD);
                w_clr_n = (w_op_nxt == OP_CL);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clr <= 1'b1;
            r_npl <= 1'b1;
            r_cpu <= 1'b1;
            r_cpd <= 1'b1;
        end else begin
            r_clr <= w_clr_n;
            r_npl <= w_npl_n;
            r_cpu <= w_cpu_n;
            r_cpd <= w_cpd_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmd    <= '0;
            r_tmr    <= '0;
            r_shadow <= '0;
            r_p      <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_tmr <= (w_next != r_state) ? '0 : r_tmr + CW'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd.op  <= i_cmd_op;
                        r_cmd.rem <= i_cmd_arg;
                        r_carry   <= 1'b0;
                        r_borrow  <= 1'b0;
                        if (i_cmd_op == OP_LD)
                            r_p <= i_cmd_arg;
                    end
                end
                S_LOW: begin
                    if (r_cmd.op == OP_UP && !i_ntcu)
                        r_carry <= 1'b1;
                    if (r_cmd.op == OP_DN && !i_ntcd)
                        r_borrow <= 1'b1;
                    if (w_lo_last)
                        r_shadow <= (r_cmd.op == OP_UP) ? r_shadow + WIDTH'(1)
                                                        : r_shadow - WIDTH'(1);
                end
                S_HIGH: begin
                    if (w_hi_last)
                        r_cmd.rem <= r_cmd.rem - WIDTH'(1);
                end
                S_LOAD: begin
                    if (w_lo_last)
                        r_shadow <= (r_cmd.op == OP_LD) ? r_p : '0;
                end
                default: ;
            endcase
        end
    end

`ifdef COUNTER_193_DRIVER_CHECK_EN
    logic r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_err <= 1'b0;
        else if (w_accept)
            r_err <= 1'b0;
        else if (r_state == S_CHECK && i_q != r_shadow)
            r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    logic w_unused_q;
    assign w_unused_q = ^i_q;
    assign o_err      = 1'b0;
`endif

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_carry     = r_carry;
    assign o_borrow    = r_borrow;
    assign o_shadow    = r_shadow;
    assign o_clr       = r_clr;
    assign o_npl       = r_npl;
    assign o_p         = r_p;
    assign o_cpu       = r_cpu;
    assign o_cpd       = r_cpd;

endmodule

// File: tb/tb_counter_193_driver.sv
// Directed bench for counter_193_driver with a behavioural 74x193 attached to the strobes.
// Honours COUNTER_193_DRIVER_CHECK_EN (extra CHECK clock, err on q mismatch).
module tb_counter_193_driver;
    localparam int W = 4;
`ifdef COUNTER_193_DRIVER_CHECK_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif
    localparam logic [1:0] UP = 2'b00;
    localparam logic [1:0] DN = 2'b01;
    localparam logic [1:0] LD = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] arg;
        logic [W-1:0] sh;
        logic [W-1:0] p;
        logic         c;
        logic         b;
        int           cyc;
        int           ncpu;
        int           ncpd;
        int           nnpl;
        int           nclr;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_arg = '0;
    logic         cmd_ready, done, carry, borrow, clr, npl, cpu, cpd, err;
    logic [W-1:0] shadow, p, q;
    logic         ntcu, ntcd;
    logic [W-1:0] mq = 4'h5;
    logic         stuck = 1'b0;
    logic         pcpu = 1'b1;
    logic         pcpd = 1'b1;
    int           checks = 0;
    int           errors = 0;

    counter_193_driver #(.WIDTH(W), .PULSE_LO(2), .PULSE_HI(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_arg(cmd_arg), .o_done(done), .o_carry(carry),
        .o_borrow(borrow), .o_shadow(shadow), .o_clr(clr), .o_npl(npl), .o_p(p),
        .o_cpu(cpu), .o_cpd(cpd), .i_q(q), .i_ntcu(ntcu), .i_ntcd(ntcd), .o_err(err)
    );

    always #5 clk = ~clk;

    // 193 model: strobes are stable mid-cycle, so edges on cpu/cpd are detected at negedge
    assign q    = stuck ? 4'h0 : mq;
    assign ntcu = !((mq == 4'hF) && !cpu);
    assign ntcd = !((mq == 4'h0) && !cpd);

    always @(negedge clk) begin
        if (clr)
            mq <= 4'h0;
        else if (!npl)
            mq <= p;
        else if (cpu && !pcpu)
            mq <= mq + 4'd1;
        else if (cpd && !pcpd)
            mq <= mq - 4'd1;
        pcpu <= cpu;
        pcpd <= cpd;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] op, input logic [W-1:0] arg);
        int k = 0;
        while (!cmd_ready && k < 100) begin
            step();
            k++;
        end
        chk("ready_before_accept", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
    endtask

    // noise keeps a bogus load request on the bus while busy; it must be ignored
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg, input bit noise,
                           output int cyc, output int ncpu, output int ncpd,
                           output int nnpl, output int nclr, output int viol);
        accept(op, arg);
        cyc = 1; ncpu = 0; ncpd = 0; nnpl = 0; nclr = 0; viol = 0;
        while (!done && cyc < 200) begin
            if (!cpu) ncpu++;
            if (!cpd) ncpd++;
            if (!npl) nnpl++;
            if (clr)  nclr++;
            if ((!cpu && !cpd) || (!npl && clr)) viol++;
            if (noise) begin
                cmd_valid = 1'b1;
                cmd_op    = LD;
                cmd_arg   = 4'h9;
            end
            step();
            cyc++;
        end
        cmd_valid = 1'b0;
        chk("done_seen", int'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[11];
        int cyc, ncpu, ncpd, nnpl, nclr, viol;

        vt[0]  = '{LD, 4'hD, 4'hD, 4'hD, 1'b0, 1'b0,  3 + XL,  0, 0, 2, 0};
        vt[1]  = '{UP, 4'h5, 4'h2, 4'hD, 1'b1, 1'b0, 21 + XL, 10, 0, 0, 0};
        vt[2]  = '{LD, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0,  3 + XL,  0, 0, 2, 0};
        vt[3]  = '{DN, 4'h3, 4'hE, 4'h1, 1'b0, 1'b1, 13 + XL,  0, 6, 0, 0};
        vt[4]  = '{DN, 4'h0, 4'hE, 4'h1, 1'b0, 1'b0,  1 + XL,  0, 0, 0, 0};
        vt[5]  = '{UP, 4'h1, 4'hF, 4'h1, 1'b0, 1'b0,  5 + XL,  2, 0, 0, 0};
        vt[6]  = '{UP, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0,  5 + XL,  2, 0, 0, 0};
        vt[7]  = '{LD, 4'h7, 4'h7, 4'h7, 1'b0, 1'b0,  3 + XL,  0, 0, 2, 0};
        vt[8]  = '{CL, 4'h5, 4'h0, 4'h7, 1'b0, 1'b0,  3 + XL,  0, 0, 0, 2};
        vt[9]  = '{DN, 4'h1, 4'hF, 4'h7, 1'b0, 1'b1,  5 + XL,  0, 2, 0, 0};
        vt[10] = '{UP, 4'hF, 4'hE, 4'h7, 1'b1, 1'b0, 61 + XL, 30, 0, 0, 0};

        // reset held three clocks, then one CLEAR clock, then IDLE
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_clr", int'(clr), 1);
            chk("rst_cpu_cpd_npl", int'({cpu, cpd, npl}), 7);
            chk("rst_ready", int'(cmd_ready), 0);
            chk("rst_regs", int'({done, carry, borrow, err, shadow, p}), 0);
        end
        reset = 1'b0;
        step();
        chk("clear_hold_clr", int'(clr), 1);
        chk("clear_hold_ready", int'(cmd_ready), 0);
        step();
        chk("idle_clr", int'(clr), 0);
        chk("idle_ready", int'(cmd_ready), 1);
        chk("idle_q", int'(q), 0);

        foreach (vt[i]) begin
            run_cmd(vt[i].op, vt[i].arg, 1'b1, cyc, ncpu, ncpd, nnpl, nclr, viol);
            chk($sformatf("v%0d_latency", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d_shadow", i), int'(shadow), int'(vt[i].sh));
            chk($sformatf("v%0d_q", i), int'(q), int'(vt[i].sh));
            chk($sformatf("v%0d_p", i), int'(p), int'(vt[i].p));
            chk($sformatf("v%0d_carry", i), int'(carry), int'(vt[i].c));
            chk($sformatf("v%0d_borrow", i), int'(borrow), int'(vt[i].b));
            chk($sformatf("v%0d_err", i), int'(err), 0);
            chk($sformatf("v%0d_cpu_low_clks", i), ncpu, vt[i].ncpu);
            chk($sformatf("v%0d_cpd_low_clks", i), ncpd, vt[i].ncpd);
            chk($sformatf("v%0d_npl_low_clks", i), nnpl, vt[i].nnpl);
            chk($sformatf("v%0d_clr_high_clks", i), nclr, vt[i].nclr);
            chk($sformatf("v%0d_strobe_overlap", i), viol, 0);
            step();
            chk($sformatf("v%0d_done_one_clk", i), int'(done), 0);
            chk($sformatf("v%0d_back_idle", i), int'(cmd_ready), 1);
        end

        // reset during the LOW phase of an up pulse
        accept(UP, 4'h3);
        chk("mid_cpu_low", int'(cpu), 0);
        reset = 1'b1;
        step();
        chk("mid_rst_cpu", int'(cpu), 1);
        chk("mid_rst_clr", int'(clr), 1);
        chk("mid_rst_npl_cpd", int'({npl, cpd}), 3);
        chk("mid_rst_ready", int'(cmd_ready), 0);
        reset = 1'b0;
        step();
        chk("mid_clear_hold", int'(clr), 1);
        step();
        chk("mid_ready", int'(cmd_ready), 1);
        chk("mid_shadow", int'(shadow), 0);
        chk("mid_q", int'(q), 0);

        // counter readback stuck at zero
        stuck = 1'b1;
        run_cmd(UP, 4'h1, 1'b0, cyc, ncpu, ncpd, nnpl, nclr, viol);
        chk("stuck_latency", cyc, 5 + XL);
        chk("stuck_shadow", int'(shadow), 1);
        chk("stuck_err", int'(err), XL);
        stuck = 1'b0;
        step();
        chk("stuck_err_sticky", int'(err), XL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
